stash_nav: RTL and testbench

Parametrised sample stash with bidirectional navigation. It stores the last DEPTH samples of width WIDTH in a circular buffer. The newest sample is shown after every write, and the user can step through the stored history toward older or newer samples. It also supports freeze, clear, and sticky overflow/drop flags. It sits between the sample source (switch/ADC capture) and the display path of the lab designs.

---
 rtl/stash_pkg.sv | 26 ++
 rtl/stash_nav_ring_ctr.sv | 43 ++++
 rtl/stash_nav.sv | 108 ++++++++++
 tb/tb_stash_nav.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/stash_pkg.sv
// Shared widths and wrap arithmetic for the sample stash.
// Latency: none, constant functions only.
// Backpressure: none.
package stash_pkg;

    // Pointer width: enough bits to address DEPTH slots, never less than 1.
    function automatic int ptr_w(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

    // Counter width: enough bits to hold the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // (a - 1 - b) mod depth for a, b in [0, depth-1].
    // The raw difference is never below -depth, so one conditional add is
    // enough, and depth does not have to be a power of two.
    function automatic int wrap_sub(input int a, input int b, input int depth);
        int d;
        d = a - 1 - b;
        if (d < 0) d = d + depth;
        return d;
    endfunction

endpackage

// File: rtl/stash_nav_ring_ctr.sv
// Wrapping up/down counter whose wrap point is a runtime limit.
// Latency: value updates one edge after zero/up/dn.
// Backpressure: none; a step is taken on every edge where it is requested.
//
// Ports: clk, reset (async active-low), zero (force 0, wins over steps),
//        up (limit-1 -> 0), dn (0 -> limit-1, only with STASH_NAV_PREV_EN),
//        limit (current modulus, must be >= 1 when stepping), value.
module ring_ctr #(
    parameter int VAL_W = 3,
    parameter int LIM_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             zero,
    input  logic             up,
    input  logic             dn,
    input  logic [LIM_W-1:0] limit,
    output logic [VAL_W-1:0] value
);

`ifndef STASH_NAV_PREV_EN
    // Down stepping is not built; the port is kept so both builds share
    // one instantiation.
    logic unused_dn;
    assign unused_dn = dn;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (zero) begin
            value <= '0;
        end else if (up) begin
            value <= (LIM_W'(value) == limit - LIM_W'(1)) ? '0 : value + VAL_W'(1);
        end
`ifdef STASH_NAV_PREV_EN
        else if (dn) begin
            value <= (value == '0) ? VAL_W'(limit - LIM_W'(1)) : value - VAL_W'(1);
        end
`endif
    end

endmodule

// File: rtl/stash_nav.sv
// Circular stash of the last DEPTH samples with older/newer navigation.
// Latency: write and navigation take effect one edge later; sample_out is combinational from state.
// Backpressure: none; writes while frozen are dropped and flagged.
//
// Ports: clk, reset (async active-low), sample_in/sample_in_valid (store),
//        next_sample (older), prev_sample (newer), freeze (drop writes),
//        clear (sync empty); sample_out/sample_out_valid, index (age of
//        shown sample), count, full, overflow (sticky), dropped (sticky).
// Build option: STASH_NAV_PREV_EN enables prev_sample; otherwise it is
// ignored and next_sample alone steps, even when both are high.
module stash_nav
    import stash_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 5,
    localparam int PTR_W = ptr_w(DEPTH),
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_in_valid,
    input  logic             next_sample,
    input  logic             prev_sample,
    input  logic             freeze,
    input  logic             clear,
    output logic [WIDTH-1:0] sample_out,
    output logic             sample_out_valid,
    output logic [PTR_W-1:0] index,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             overflow,
    output logic             dropped
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] shown;
    logic             wr;
    logic             drop;
    logic             nav_ok;
    logic             step_up;
    logic             step_dn;

    assign wr     = sample_in_valid && !freeze && !clear;
    assign drop   = sample_in_valid &&  freeze && !clear;
    // A real write forces index to 0, so navigation only matters otherwise.
    assign nav_ok = !clear && !wr && (count != '0);

`ifdef STASH_NAV_PREV_EN
    assign step_up = nav_ok && next_sample && !prev_sample;
    assign step_dn = nav_ok && prev_sample && !next_sample;
`else
    logic unused_prev;
    assign unused_prev = prev_sample;
    assign step_up = nav_ok && next_sample;
    assign step_dn = 1'b0;
`endif

    ring_ctr #(.VAL_W(PTR_W), .LIM_W(CNT_W)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .zero  (clear),
        .up    (wr),
        .dn    (1'b0),
        .limit (DEPTH_C),
        .value (wr_ptr)
    );

    ring_ctr #(.VAL_W(PTR_W), .LIM_W(CNT_W)) u_index (
        .clk   (clk),
        .reset (reset),
        .zero  (clear || wr),
        .up    (step_up),
        .dn    (step_dn),
        .limit (count),
        .value (index)
    );

    // Storage has no reset: contents are meaningless whenever count is 0.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= sample_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            overflow <= 1'b0;
            dropped  <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            overflow <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            if (wr && !full) count <= count + CNT_W'(1);
            if (wr && full)  overflow <= 1'b1;
            if (drop)        dropped  <= 1'b1;
        end
    end

    assign shown            = PTR_W'(wrap_sub(int'(wr_ptr), int'(index), DEPTH));
    assign full             = (count == DEPTH_C);
    assign sample_out_valid = (count != '0);
    assign sample_out       = sample_out_valid ? mem[shown] : '0;

endmodule

// File: tb/tb_stash_nav.sv
// Directed bench for stash_nav (WIDTH=8, DEPTH=5) with hand-computed values.
module tb_stash_nav;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] sample_in = '0;
    logic       sample_in_valid = 1'b0;
    logic       next_sample = 1'b0;
    logic       prev_sample = 1'b0;
    logic       freeze = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] sample_out;
    logic       sample_out_valid;
    logic [2:0] index;
    logic [2:0] count;
    logic       full;
    logic       overflow;
    logic       dropped;

    int checks = 0;
    int errors = 0;

    stash_nav #(.WIDTH(8), .DEPTH(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .sample_in        (sample_in),
        .sample_in_valid  (sample_in_valid),
        .next_sample      (next_sample),
        .prev_sample      (prev_sample),
        .freeze           (freeze),
        .clear            (clear),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .index            (index),
        .count            (count),
        .full             (full),
        .overflow         (overflow),
        .dropped          (dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, take the edge, sample 1 time unit later.
    task automatic cyc(input logic v, input logic [7:0] d, input logic nx,
                       input logic pv, input logic fz, input logic cl);
        sample_in_valid = v;
        sample_in       = d;
        next_sample     = nx;
        prev_sample     = pv;
        freeze          = fz;
        clear           = cl;
        @(posedge clk);
        #1;
        sample_in_valid = 1'b0;
        next_sample     = 1'b0;
        prev_sample     = 1'b0;
        freeze          = 1'b0;
        clear           = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_state(input string tag, input logic [7:0] o, input int idx,
                             input int cnt, input logic ov, input logic dr);
        chk({tag, ".out"},   32'(sample_out), 32'(o));
        chk({tag, ".idx"},   32'(index),      32'(idx));
        chk({tag, ".cnt"},   32'(count),      32'(cnt));
        chk({tag, ".vld"},   32'(sample_out_valid), 32'(cnt != 0));
        chk({tag, ".full"},  32'(full),       32'(cnt == 5));
        chk({tag, ".ovf"},   32'(overflow),   32'(ov));
        chk({tag, ".drop"},  32'(dropped),    32'(dr));
    endtask

    logic [7:0] seq_old [5];
    int         seq_idx [5];

    initial begin
        seq_old = '{8'h06, 8'h05, 8'h04, 8'h03, 8'h07};
        seq_idx = '{1, 2, 3, 4, 0};

        #12;
        chk_state("reset", 8'h00, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_state("post_rst", 8'h00, 0, 0, 1'b0, 1'b0);

        wr(8'h11); chk_state("w11", 8'h11, 0, 1, 1'b0, 1'b0);
        wr(8'h22); chk_state("w22", 8'h22, 0, 2, 1'b0, 1'b0);
        wr(8'h33); chk_state("w33", 8'h33, 0, 3, 1'b0, 1'b0);

        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_state("clr1", 8'h00, 0, 0, 1'b0, 1'b0);

        for (int i = 1; i <= 7; i++) wr(8'(i));
        chk_state("w07", 8'h07, 0, 5, 1'b1, 1'b0);

        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("nav.out", 32'(sample_out), 32'(seq_old[i]));
            chk("nav.idx", 32'(index), 32'(seq_idx[i]));
        end

`ifdef STASH_NAV_PREV_EN
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_state("prev_wrap", 8'h03, 4, 5, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_state("both", 8'h03, 4, 5, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_state("prev", 8'h04, 3, 5, 1'b1, 1'b0);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_state("frz", 8'h04, 3, 5, 1'b1, 1'b1);
`else
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_state("prev_ign", 8'h07, 0, 5, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_state("both_step", 8'h06, 1, 5, 1'b1, 1'b0);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_state("frz", 8'h06, 1, 5, 1'b1, 1'b1);
`endif

        wr(8'hBB);
        chk_state("wBB", 8'hBB, 0, 5, 1'b1, 1'b1);

        // Dropped write still lets navigation through.
        cyc(1'b1, 8'hCC, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_state("drop_nav", 8'h07, 1, 5, 1'b1, 1'b1);

        // Write beats a same-cycle step.
        cyc(1'b1, 8'hDD, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_state("w_nav", 8'hDD, 0, 5, 1'b1, 1'b1);

        // Clear beats a same-cycle write.
        cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_state("clr2", 8'h00, 0, 0, 1'b0, 1'b0);

        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_state("nav_empty", 8'h00, 0, 0, 1'b0, 1'b0);

        wr(8'h44);
        wr(8'h55);
        cyc(1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_state("pre_arst", 8'h55, 0, 2, 1'b0, 1'b1);

        // Async reset in mid-cycle while a write is being requested.
        sample_in_valid = 1'b1;
        sample_in       = 8'h77;
        #2;
        reset = 1'b0;
        #1;
        chk_state("arst", 8'h00, 0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_state("arst_hold", 8'h00, 0, 0, 1'b0, 1'b0);
        sample_in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wr(8'h66);
        chk_state("after_arst", 8'h66, 0, 1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
